// File: rtl/half_adder_bist_pkg.sv
// Shared types and helpers for the half-adder self-test controller.
package ha_bist_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } ha_bist_state_t;

   localparam int HA_NUM_VECTORS = 4;

   // Golden half-adder response, packed as {sum, carry}.
   function automatic logic [1:0] ha_expect(input logic a, input logic b);
      return {a ^ b, a & b};
   endfunction

endpackage

// File: rtl/half_adder_bist_if.sv
// Control/status and DUT-drive signals of the half-adder self-test controller.
interface half_adder_bist_if;
   logic       start;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] err_count;
   logic [1:0] fail_vec;
   logic       fail_valid;
   logic       dut_a;
   logic       dut_b;
   logic       dut_s;
   logic       dut_c;

   // Environment side: host control plus the half adder under test.
   modport master (
      output start,
      input  busy, done, pass, err_count, fail_vec, fail_valid,
      input  dut_a, dut_b,
      output dut_s, dut_c
   );

   // Self-test controller side.
   modport slave (
      input  start,
      output busy, done, pass, err_count, fail_vec, fail_valid,
      output dut_a, dut_b,
      input  dut_s, dut_c
   );
endinterface

// File: rtl/half_adder.sv
// Combinational half adder exercised by the self-test controller.
module half_adder (
   input  logic A,
   input  logic B,
   output logic S,
   output logic C
);
   assign S = A ^ B;
   assign C = A & B;
endmodule

// File: rtl/half_adder_bist.sv
// Self-test controller: walks the four half-adder input vectors, holds each
// for SETTLE_CYCLES, samples the adder on the following cycle and records
// mismatches, the first failing vector and an overall pass flag.
module half_adder_bist
   import ha_bist_pkg::*;
#(
   parameter int SETTLE_CYCLES = 3
) (
   input logic              clk,
   input logic              rst,
   half_adder_bist_if.slave bus
);

   localparam int                CW       = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0]     CNT_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [1:0]        VEC_LAST = 2'(HA_NUM_VECTORS - 1);

   ha_bist_state_t state_r;
   logic [1:0]     vec_r;
   logic [CW-1:0]  cnt_r;
   logic           busy_r;
   logic           done_r;
   logic           pass_r;
   logic [2:0]     err_count_r;
   logic [1:0]     fail_vec_r;
   logic           fail_valid_r;
   logic           dut_a_r;
   logic           dut_b_r;

   logic [1:0]     exp_s;
   logic           mismatch_s;
   logic [2:0]     err_next_s;

   // Compare the sampled adder outputs against the golden response.
   always_comb begin
      exp_s      = ha_expect(dut_a_r, dut_b_r);
      mismatch_s = ({bus.dut_s, bus.dut_c} != exp_s);
      err_next_s = err_count_r + {2'b00, mismatch_s};
   end

   // Test sequencer: state, vector/settle counters and registered results.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         vec_r        <= 2'd0;
         cnt_r        <= '0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         pass_r       <= 1'b0;
         err_count_r  <= 3'd0;
         fail_vec_r   <= 2'd0;
         fail_valid_r <= 1'b0;
         dut_a_r      <= 1'b0;
         dut_b_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (bus.start) begin
                  state_r      <= APPLY;
                  vec_r        <= 2'd0;
                  cnt_r        <= '0;
                  busy_r       <= 1'b1;
                  done_r       <= 1'b0;
                  pass_r       <= 1'b0;
                  err_count_r  <= 3'd0;
                  fail_vec_r   <= 2'd0;
                  fail_valid_r <= 1'b0;
                  dut_a_r      <= 1'b0;
                  dut_b_r      <= 1'b0;
               end else begin
                  state_r <= state_r;
               end
            end
            APPLY: begin
               if (cnt_r == CNT_LAST) begin
                  state_r <= CHECK;
               end else begin
                  cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
               end
            end
            CHECK: begin
               err_count_r <= err_next_s;
               // Only the first mismatch of a run is reported as fail_vec.
               if (mismatch_s && !fail_valid_r) begin
                  fail_vec_r   <= vec_r;
                  fail_valid_r <= 1'b1;
               end else begin
                  fail_valid_r <= fail_valid_r;
               end
               if (vec_r == VEC_LAST) begin
                  state_r <= DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  pass_r  <= (err_next_s == 3'd0);
                  dut_a_r <= 1'b0;
                  dut_b_r <= 1'b0;
               end else begin
                  state_r            <= APPLY;
                  vec_r              <= vec_r + 2'd1;
                  cnt_r              <= '0;
                  {dut_a_r, dut_b_r} <= vec_r + 2'd1;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.pass       = pass_r;
   assign bus.err_count  = err_count_r;
   assign bus.fail_vec   = fail_vec_r;
   assign bus.fail_valid = fail_valid_r;
   assign bus.dut_a      = dut_a_r;
   assign bus.dut_b      = dut_b_r;

endmodule

// File: tb/tb_half_adder_bist.sv
// Bench for half_adder_bist: two controllers (SETTLE_CYCLES 3 and 1), each
// driving a half_adder; faults are injected on the first one through muxes.
module tb_half_adder_bist;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start3 = 1'b0;
   logic       start1 = 1'b0;
   logic [3:0] sum_flip = 4'h0;
   logic [3:0] carry_flip = 4'h0;
   logic       carry_sa0 = 1'b0;
   logic       sel = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;

   half_adder_bist_if bus3 ();
   half_adder_bist_if bus1 ();

   logic ha3_s, ha3_c, ha1_s, ha1_c;

   half_adder u_ha3 (.A(bus3.dut_a), .B(bus3.dut_b), .S(ha3_s), .C(ha3_c));
   half_adder u_ha1 (.A(bus1.dut_a), .B(bus1.dut_b), .S(ha1_s), .C(ha1_c));

   assign bus3.dut_s = ha3_s ^ sum_flip[{bus3.dut_a, bus3.dut_b}];
   assign bus3.dut_c = carry_sa0 ? 1'b0 : (ha3_c ^ carry_flip[{bus3.dut_a, bus3.dut_b}]);
   assign bus3.start = start3;
   assign bus1.dut_s = ha1_s;
   assign bus1.dut_c = ha1_c;
   assign bus1.start = start1;

   half_adder_bist #(.SETTLE_CYCLES(3)) u_bist3 (.clk(clk), .rst(rst), .bus(bus3));
   half_adder_bist #(.SETTLE_CYCLES(1)) u_bist1 (.clk(clk), .rst(rst), .bus(bus1));

   // Observed signals of the controller currently under test.
   logic       m_busy, m_done, m_pass, m_fvalid;
   logic [2:0] m_err;
   logic [1:0] m_fvec, m_ab;
   assign m_busy   = sel ? bus1.busy       : bus3.busy;
   assign m_done   = sel ? bus1.done       : bus3.done;
   assign m_pass   = sel ? bus1.pass       : bus3.pass;
   assign m_fvalid = sel ? bus1.fail_valid : bus3.fail_valid;
   assign m_err    = sel ? bus1.err_count  : bus3.err_count;
   assign m_fvec   = sel ? bus1.fail_vec   : bus3.fail_vec;
   assign m_ab     = sel ? {bus1.dut_a, bus1.dut_b} : {bus3.dut_a, bus3.dut_b};

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_start(input logic v);
      if (sel) start1 = v;
      else     start3 = v;
   endtask

   // Reference: evaluate each vector arithmetically with the injected faults.
   function automatic void model(input logic [3:0] sf, input logic [3:0] cf, input logic sa0,
                                 output int err, output int first);
      err   = 0;
      first = 0;
      for (int v = 0; v < 4; v++) begin
         int a, b, s, c, os, oc;
         a  = v / 2;
         b  = v % 2;
         s  = (a + b) % 2;
         c  = (a + b) / 2;
         os = s ^ int'(sf[v]);
         oc = sa0 ? 0 : (c ^ int'(cf[v]));
         if (os != s || oc != c) begin
            if (err == 0) first = v;
            err++;
         end
      end
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},   32'(m_busy),   32'd0);
      check({tag, "_done"},   32'(m_done),   32'd0);
      check({tag, "_pass"},   32'(m_pass),   32'd0);
      check({tag, "_err"},    32'(m_err),    32'd0);
      check({tag, "_fvec"},   32'(m_fvec),   32'd0);
      check({tag, "_fvalid"}, 32'(m_fvalid), 32'd0);
      check({tag, "_ab"},     32'(m_ab),     32'd0);
   endtask

   // One full run: pulse start, optionally pulse start again mid-run, then
   // check timing, the vector walk and the final results.
   task automatic run_check(input string tag, input int settle, input logic [3:0] sf,
                            input logic [3:0] cf, input logic sa0, input int pulse_at);
      int err_exp, first_exp, cyc, hold;
      sum_flip   = sel ? 4'h0 : sf;
      carry_flip = sel ? 4'h0 : cf;
      carry_sa0  = sel ? 1'b0 : sa0;
      model(sum_flip, carry_flip, carry_sa0, err_exp, first_exp);
      tick();
      set_start(1'b1);
      tick();
      set_start(1'b0);
      check({tag, "_busy_rise"}, 32'(m_busy), 32'd1);
      check({tag, "_clr_done"},  32'(m_done), 32'd0);
      check({tag, "_clr_err"},   32'(m_err),  32'd0);
      check({tag, "_clr_fval"},  32'(m_fvalid), 32'd0);
      check({tag, "_clr_pass"},  32'(m_pass), 32'd0);
      cyc = 0;
      while (!m_done && cyc < 200) begin
         check({tag, "_ab_walk"}, 32'(m_ab), 32'(cyc / (settle + 1)));
         set_start(cyc == pulse_at);
         tick();
         cyc++;
      end
      set_start(1'b0);
      check({tag, "_done_lat"}, 32'(cyc), 32'(4 * (settle + 1)));
      check({tag, "_busy_low"}, 32'(m_busy), 32'd0);
      check({tag, "_ab_idle"},  32'(m_ab), 32'd0);
      check({tag, "_err"},      32'(m_err), 32'(err_exp));
      check({tag, "_pass"},     32'(m_pass), 32'(err_exp == 0));
      check({tag, "_fvalid"},   32'(m_fvalid), 32'(err_exp != 0));
      check({tag, "_fvec"},     32'(m_fvec), 32'(first_exp));
      hold = $urandom_range(1, 3);
      repeat (hold) tick();
      check({tag, "_done_hold"}, 32'(m_done), 32'd1);
      check({tag, "_err_hold"},  32'(m_err), 32'(err_exp));
   endtask

   initial begin
      int i;
      rst = 1'b1;
      repeat (3) tick();
      sel = 1'b0;
      check_reset_outputs("rst3");
      sel = 1'b1;
      check_reset_outputs("rst1");
      rst = 1'b0;

      // Directed runs on SETTLE_CYCLES=3.
      sel = 1'b0;
      run_check("good",     3, 4'h0, 4'h0, 1'b0, -1);
      run_check("carry_sa0", 3, 4'h0, 4'h0, 1'b1, -1);
      run_check("sum_inv",  3, 4'hF, 4'h0, 1'b0, -1);
      run_check("busy_start", 3, 4'h0, 4'h0, 1'b0, 6);

      // Randomized fault patterns and stray start pulses.
      for (int r = 0; r < 8; r++) begin
         logic [3:0] sf, cf;
         logic       sa0;
         int         p;
         sf  = 4'($urandom_range(0, 15));
         cf  = 4'($urandom_range(0, 15));
         sa0 = ($urandom_range(0, 3) == 0);
         p   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1;
         run_check("rand", 3, sf, cf, sa0, p);
      end

      // start held high: DONE lasts one cycle, then a new run begins.
      sum_flip = 4'h0; carry_flip = 4'h0; carry_sa0 = 1'b0;
      start3 = 1'b1;
      tick();
      i = 0;
      while (!m_done && i < 100) begin
         tick();
         i++;
      end
      check("b2b_done_seen", 32'(m_done), 32'd1);
      tick();
      check("b2b_busy", 32'(m_busy), 32'd1);
      check("b2b_done", 32'(m_done), 32'd0);
      check("b2b_ab",   32'(m_ab),   32'd0);
      start3 = 1'b0;
      i = 0;
      while (!m_done && i < 100) begin
         tick();
         i++;
      end
      check("b2b_pass", 32'(m_pass), 32'd1);

      // Reset during vector 2 (with start also high), then a clean run.
      sum_flip = 4'hF;
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      i = 0;
      while (m_ab != 2'd2 && i < 40) begin
         tick();
         i++;
      end
      check("midrst_vec2", 32'(m_ab), 32'd2);
      check("midrst_err2", 32'(m_err), 32'd2);
      rst = 1'b1;
      start3 = 1'b1;
      tick();
      check_reset_outputs("midrst");
      rst = 1'b0;
      start3 = 1'b0;
      tick();
      check("midrst_idle", 32'(m_busy), 32'd0);
      run_check("after_rst", 3, 4'h0, 4'h0, 1'b0, -1);

      // SETTLE_CYCLES=1 controller.
      sel = 1'b1;
      run_check("settle1", 1, 4'h0, 4'h0, 1'b0, -1);
      run_check("settle1_busy_start", 1, 4'h0, 4'h0, 1'b0, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/half_adder_bist.md
# half_adder_bist

Hardware self-test controller for the combinational half adder. It drives the four input vectors onto an external `half_adder` instance, samples that instance's `S` and `C` outputs, and compares them against the expected sum and carry. It reports pass/fail, an error count and the first failing vector. It is the hardware counterpart of the bench stimulus: on-chip, repeatable and restartable.

## Interface
- `SETTLE_CYCLES`, default 3: cycles each vector is held before sampling; legal range ≥1.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: launches a run when sampled high in IDLE or DONE; ignored otherwise.
- `dut_a` out 1: drives DUT `A`.
- `dut_b` out 1: drives DUT `B`.
- `dut_s` in 1: DUT sum output `S`.
- `dut_c` in 1: DUT carry output `C`.
- `busy` out 1: high in APPLY and CHECK.
- `done` out 1: high in DONE; level, held until the next start or reset.
- `pass` out 1: valid while `done`; high iff `err_count`==0.
- `err_count` out 3: number of mismatching vectors in the last run (0..4).
- `fail_vec` out 2: index `{A,B}` of the first mismatching vector.
- `fail_valid` out 1: high once any mismatch has been recorded in the current run.

## Operation
- States: IDLE, APPLY, CHECK, DONE.
- Vector index `vec[1:0]`, in order 0,1,2,3. `dut_a`=`vec[1]`, `dut_b`=`vec[0]`.
- Expected values: `exp_s = dut_a ^ dut_b`, `exp_c = dut_a & dut_b`.

State transitions:
- **IDLE or DONE, `start`=1:**
  - Go to APPLY.
  - Set `vec`=0 and settle counter `cnt`=0.
  - Clear `err_count`, `fail_vec`, `fail_valid`, `pass` and `done`.
- **APPLY:**
  - `cnt` increments each cycle.
  - When `cnt`==`SETTLE_CYCLES`-1, go to CHECK.
- **CHECK:** one cycle. Compare `{dut_s,dut_c}` against `{exp_s,exp_c}`.
  - On mismatch, increment `err_count`.
  - On a mismatch with `fail_valid`=0, also load `fail_vec`=`vec` and set `fail_valid`=1. Later mismatches do not overwrite `fail_vec`.
  - If `vec`==3, go to DONE. Otherwise increment `vec`, clear `cnt` and return to APPLY.
- **DONE:**
  - `done`=1, `busy`=0.
  - `pass`=(`err_count`==0), registered on entry to DONE.
  - Results hold until `start` or `rst`.

Other rules:
- `dut_a`/`dut_b` are registered and stay stable through APPLY and CHECK of the same vector. In IDLE and DONE they are 0.
- `start` while `busy` is ignored and does not extend or restart the run.
- `err_count` needs no saturation: the maximum is 4, which fits in 3 bits.

## Timing
- Reset values:
  - State is IDLE.
  - `dut_a`, `dut_b`, `busy`, `done`, `pass`, `err_count`, `fail_vec` and `fail_valid` are all 0.
- `busy` rises on the first edge after `start` is sampled.
- Each vector occupies `SETTLE_CYCLES`+1 cycles (APPLY plus CHECK).
- `done` rises exactly 4·(`SETTLE_CYCLES`+1) cycles after the `busy` rise. Example: with `SETTLE_CYCLES`=3, that is 16 cycles.
- DUT outputs are sampled on the CHECK-cycle edge. The DUT therefore sees each vector for at least `SETTLE_CYCLES` full cycles before sampling.
- `rst` mid-run: on the next edge, return to IDLE with all outputs at their reset values. No partial results are retained.
- `rst` and `start` high together: `rst` wins.
- `start` held high continuously causes back-to-back runs. DONE lasts one cycle, then a new run starts.

## Structure
- Package `ha_bist_pkg` contains:
  - State enum `ha_bist_state_t` (IDLE, APPLY, CHECK, DONE).
  - Constant `HA_NUM_VECTORS`=4.
  - Function `ha_expect(a,b)` returning `{s,c}`.
- The counter width is `$clog2(SETTLE_CYCLES+1)`, local to the block.
- No sub-module in the RTL: the FSM, counter and comparator are a single module.
- The bench instantiates `half_adder` as the DUT alongside `half_adder_bist`. Fault variants are injected with wrapper muxes in the bench only.

## Test plan
- **Good DUT, `SETTLE_CYCLES`=3, pulse `start`:**
  - `done` arrives 16 cycles after `busy` rises.
  - `pass`=1, `err_count`=0, `fail_valid`=0.
  - `dut_a`/`dut_b` step through 00, 01, 10, 11, each held 4 cycles.
- **Carry stuck-at-0:** `err_count`=1, `fail_vec`=3, `fail_valid`=1, `pass`=0.
- **Sum inverted:** `err_count`=4, `fail_vec`=0, `pass`=0. `fail_vec` is not overwritten by later mismatches.
- **`rst` asserted during vector 2:**
  - Next edge: IDLE, all outputs 0.
  - A subsequent `start` completes a clean run with `pass`=1.
- **`start` pulsed while `busy`:** no effect; `done` timing unchanged. `start` in DONE clears the previous results and restarts from vector 0.
- **`SETTLE_CYCLES`=1:** `done` arrives 8 cycles after `busy` rises; a good DUT gives `pass`=1.
